arp_rx: RTL and testbench



---
 rtl/arp_rx.sv | 153 +++++++++++++++
 tb/tb_arp_rx.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/arp_rx.sv
// arp_rx: GMII-side ARP receive parser.
// Consumes raw GMII receive bytes, validates the preamble/SFD, the Ethernet
// header (destination MAC, ethertype) and the ARP payload (opcode, target IP),
// and pulses arp_rx_done when a request or reply addressed to BOARD_IP arrives.
//
// Ports:
//   clk          GMII receive clock; all logic on posedge
//   sys_rst      asynchronous, active-high reset
//   gmii_rx_dv   receive data valid
//   gmii_rxd     receive byte, meaningful when gmii_rx_dv=1
//   arp_rx_done  one-cycle pulse per accepted ARP frame
//   arp_rx_type  0: request (opcode 1), 1: reply (opcode 2); held until next done
//   src_mac      sender hardware address of the last accepted frame
//   src_ip       sender protocol address of the last accepted frame
module arp_rx #(
  parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
  parameter logic [31:0] BOARD_IP  = 32'hC0_A8_01_0A
) (
  input  logic        clk,
  input  logic        sys_rst,
  input  logic        gmii_rx_dv,
  input  logic [7:0]  gmii_rxd,
  output logic        arp_rx_done,
  output logic        arp_rx_type,
  output logic [47:0] src_mac,
  output logic [31:0] src_ip
);

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    ETH_HEAD,
    ARP_DATA,
    RX_END
  } state_t;

  state_t      state;
  logic [7:0]  cnt;      // byte index within the current state
  logic [47:0] shreg;    // MSB-first shift register of the received bytes
  logic [47:0] mac_tmp;  // sender MAC, committed to src_mac only on accept
  logic [31:0] ip_tmp;   // sender IP, committed to src_ip only on accept
  logic        op_tmp;   // 1 when the opcode is a reply

  // Shift register contents including the byte on the bus this cycle, so a
  // multi-byte field can be compared in full on the edge that samples its
  // last byte.
  logic [47:0] shreg_nxt;
  assign shreg_nxt = {shreg[39:0], gmii_rxd};

  // NOTE: every flop, including the data-path registers, is cleared by the
  // reset so that a reset mid-frame leaves no partially captured state.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state       <= IDLE;
      cnt         <= '0;
      shreg       <= '0;
      mac_tmp     <= '0;
      ip_tmp      <= '0;
      op_tmp      <= 1'b0;
      arp_rx_done <= 1'b0;
      arp_rx_type <= 1'b0;
      src_mac     <= '0;
      src_ip      <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout; later assignments in the
      // case below override these defaults for this edge only.
      arp_rx_done <= 1'b0;
      if (gmii_rx_dv) shreg <= shreg_nxt;

      case (state)
        IDLE: begin
          if (gmii_rx_dv) begin
            cnt   <= '0;
            state <= (gmii_rxd == 8'h55) ? PREAMBLE : RX_END;
          end
        end

        // The first 8'h55 was consumed in IDLE; six more are required here,
        // then the SFD. cnt counts the 8'h55 bytes seen in this state.
        PREAMBLE: begin
          if (!gmii_rx_dv) begin
            cnt   <= '0;
            state <= IDLE;
          end else if (gmii_rxd == 8'h55 && cnt < 8'd6) begin
            cnt <= cnt + 8'd1;
          end else if (gmii_rxd == 8'hD5 && cnt == 8'd6) begin
            cnt   <= '0;
            state <= ETH_HEAD;
          end else begin
            cnt   <= '0;
            state <= RX_END;
          end
        end

        ETH_HEAD: begin
          if (!gmii_rx_dv) begin
            cnt   <= '0;
            state <= IDLE;
          end else if (cnt == 8'd5 &&
                       shreg_nxt != BOARD_MAC && shreg_nxt != '1) begin
            cnt   <= '0;
            state <= RX_END;
          end else if (cnt == 8'd13) begin
            cnt   <= '0;
            state <= (shreg_nxt[15:0] == 16'h0806) ? ARP_DATA : RX_END;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        ARP_DATA: begin
          if (!gmii_rx_dv) begin
            cnt   <= '0;
            state <= IDLE;
          end else if (cnt == 8'd7 &&
                       shreg_nxt[15:0] != 16'h0001 &&
                       shreg_nxt[15:0] != 16'h0002) begin
            cnt   <= '0;
            state <= RX_END;
          end else if (cnt == 8'd27) begin
            cnt   <= '0;
            state <= RX_END;
            if (shreg_nxt[31:0] == BOARD_IP) begin
              arp_rx_done <= 1'b1;
              arp_rx_type <= op_tmp;
              src_mac     <= mac_tmp;
              src_ip      <= ip_tmp;
            end
          end else begin
            cnt <= cnt + 8'd1;
            if (cnt == 8'd7)  op_tmp  <= (shreg_nxt[15:0] == 16'h0002);
            if (cnt == 8'd13) mac_tmp <= shreg_nxt;
            if (cnt == 8'd17) ip_tmp  <= shreg_nxt[31:0];
          end
        end

        // Padding and FCS are skipped until the end of the frame.
        RX_END: begin
          if (!gmii_rx_dv) begin
            cnt   <= '0;
            state <= IDLE;
          end
        end

        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arp_rx.sv
// tb_arp_rx: directed bench for arp_rx. Frames are built byte by byte; every
// frame that should be accepted pushes its expected result to a scoreboard
// queue, and a monitor pops and compares on each arp_rx_done pulse.
module tb_arp_rx;

  localparam logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55;
  localparam logic [31:0] BOARD_IP  = 32'hC0_A8_01_0A;
  localparam logic [47:0] BCAST     = 48'hFFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        sys_rst;
  logic        gmii_rx_dv;
  logic [7:0]  gmii_rxd;
  logic        arp_rx_done;
  logic        arp_rx_type;
  logic [47:0] src_mac;
  logic [31:0] src_ip;

  arp_rx #(
    .BOARD_MAC(BOARD_MAC),
    .BOARD_IP (BOARD_IP)
  ) dut (
    .clk        (clk),
    .sys_rst    (sys_rst),
    .gmii_rx_dv (gmii_rx_dv),
    .gmii_rxd   (gmii_rxd),
    .arp_rx_done(arp_rx_done),
    .arp_rx_type(arp_rx_type),
    .src_mac    (src_mac),
    .src_ip     (src_ip)
  );

  always #4 clk = ~clk;

  typedef struct packed {
    logic        typ;
    logic [47:0] mac;
    logic [31:0] ip;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] frame_q[$];
  int         checks   = 0;
  int         failures = 0;
  int         pulses   = 0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: outputs are sampled on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (arp_rx_done === 1'b1) begin
        pulses++;
        check("done_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("sb_type", 64'(arp_rx_type), 64'(e.typ));
          check("sb_mac",  64'(src_mac),     64'(e.mac));
          check("sb_ip",   64'(src_ip),      64'(e.ip));
        end
      end
    end
  end

  task automatic push_field(input logic [47:0] v, input int n);
    for (int k = n - 1; k >= 0; k--) frame_q.push_back(v[k*8 +: 8]);
  endtask

  task automatic check_outputs(input string tag, input logic typ,
                               input logic [47:0] mac, input logic [31:0] ip);
    check({tag, "_done"}, 64'(arp_rx_done), 64'd0);
    check({tag, "_type"}, 64'(arp_rx_type), 64'(typ));
    check({tag, "_mac"},  64'(src_mac),     64'(mac));
    check({tag, "_ip"},   64'(src_ip),      64'(ip));
  endtask

  // Builds and drives one frame. arp_len < 28 truncates the ARP payload
  // (no padding/FCS follows); rst_idx >= 0 pulses sys_rst at that byte.
  task automatic send_frame(input logic [47:0] dst, input logic [15:0] etype,
                            input logic [15:0] op, input logic [47:0] smac,
                            input logic [31:0] sip, input logic [31:0] tip,
                            input int npre, input int arp_len, input int ifg,
                            input int rst_idx, input bit expect_done);
    frame_q.delete();
    for (int k = 0; k < npre; k++) frame_q.push_back(8'h55);
    frame_q.push_back(8'hD5);
    push_field(dst, 6);
    push_field(smac, 6);
    push_field(48'(etype), 2);
    begin
      int arp_start;
      arp_start = frame_q.size();
      push_field(48'h0001, 2);
      push_field(48'h0800, 2);
      push_field(48'h06, 1);
      push_field(48'h04, 1);
      push_field(48'(op), 2);
      push_field(smac, 6);
      push_field(48'(sip), 4);
      push_field(48'h0, 6);
      push_field(48'(tip), 4);
      if (arp_len < 28) begin
        while (frame_q.size() > arp_start + arp_len) void'(frame_q.pop_back());
      end else begin
        for (int k = 0; k < 22; k++) frame_q.push_back(8'(k + 8'hA0));
      end
    end
    if (expect_done) exp_q.push_back('{typ: (op == 16'h0002), mac: smac, ip: sip});
    for (int i = 0; i < frame_q.size(); i++) begin
      @(negedge clk);
      gmii_rx_dv = 1'b1;
      gmii_rxd   = frame_q[i];
      if (i == rst_idx) begin
        sys_rst = 1'b1;
        #1;
        check_outputs("T6_async_rst", 1'b0, 48'h0, 32'h0);
      end
      if (rst_idx >= 0 && i == rst_idx + 2) sys_rst = 1'b0;
    end
    for (int k = 0; k < ifg; k++) begin
      @(negedge clk);
      gmii_rx_dv = 1'b0;
      gmii_rxd   = 8'h00;
    end
  endtask

  localparam logic [47:0] MAC1 = 48'h000A3501FEC0;
  localparam logic [47:0] MAC2 = 48'h000A3501FEC1;
  localparam logic [47:0] MAC3 = 48'h000A3501FEC2;

  initial begin
    sys_rst    = 1'b1;
    gmii_rx_dv = 1'b0;
    gmii_rxd   = 8'h00;
    repeat (3) @(negedge clk);
    check_outputs("reset", 1'b0, 48'h0, 32'h0);
    sys_rst = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs("post_reset", 1'b0, 48'h0, 32'h0);

    // T1: broadcast request
    send_frame(BCAST, 16'h0806, 16'h0001, MAC1, 32'hC0A80166, BOARD_IP,
               7, 28, 12, -1, 1'b1);
    check("T1_pulses", 64'(pulses), 64'd1);
    check("T1_queue", 64'(exp_q.size()), 64'd0);
    check_outputs("T1_out", 1'b0, MAC1, 32'hC0A80166);

    // T2: unicast reply
    send_frame(BOARD_MAC, 16'h0806, 16'h0002, MAC2, 32'hC0A80167, BOARD_IP,
               7, 28, 12, -1, 1'b1);
    check("T2_pulses", 64'(pulses), 64'd2);
    check_outputs("T2_out", 1'b1, MAC2, 32'hC0A80167);

    // T3: wrong target IP, wrong ethertype, wrong destination MAC
    send_frame(BCAST, 16'h0806, 16'h0001, MAC1, 32'hC0A80166, 32'hC0A8010B,
               7, 28, 12, -1, 1'b0);
    send_frame(BCAST, 16'h0800, 16'h0001, MAC1, 32'hC0A80166, BOARD_IP,
               7, 28, 12, -1, 1'b0);
    send_frame(48'h001122334456, 16'h0806, 16'h0001, MAC1, 32'hC0A80166,
               BOARD_IP, 7, 28, 12, -1, 1'b0);
    check("T3_pulses", 64'(pulses), 64'd2);
    check_outputs("T3_out", 1'b1, MAC2, 32'hC0A80167);

    // T4: bad opcode, short preamble
    send_frame(BCAST, 16'h0806, 16'h0003, MAC1, 32'hC0A80166, BOARD_IP,
               7, 28, 12, -1, 1'b0);
    send_frame(BCAST, 16'h0806, 16'h0001, MAC1, 32'hC0A80166, BOARD_IP,
               5, 28, 12, -1, 1'b0);
    check("T4_pulses", 64'(pulses), 64'd2);
    check_outputs("T4_out", 1'b1, MAC2, 32'hC0A80167);

    // T5: truncated after ARP byte 20, then an immediate valid frame
    send_frame(BCAST, 16'h0806, 16'h0001, MAC3, 32'hC0A80168, BOARD_IP,
               7, 21, 1, -1, 1'b0);
    send_frame(BCAST, 16'h0806, 16'h0001, MAC1, 32'hC0A80166, BOARD_IP,
               7, 28, 12, -1, 1'b1);
    check("T5_pulses", 64'(pulses), 64'd3);
    check_outputs("T5_out", 1'b0, MAC1, 32'hC0A80166);

    // T6: reset during Ethernet header byte 3, then a valid frame
    send_frame(BCAST, 16'h0806, 16'h0002, MAC2, 32'hC0A80167, BOARD_IP,
               7, 28, 12, 7 + 1 + 3, 1'b0);
    check("T6_pulses", 64'(pulses), 64'd3);
    check_outputs("T6_after", 1'b0, 48'h0, 32'h0);
    send_frame(BCAST, 16'h0806, 16'h0002, MAC3, 32'hC0A80168, BOARD_IP,
               7, 28, 12, -1, 1'b1);
    check("T6_next_pulses", 64'(pulses), 64'd4);
    check_outputs("T6_next_out", 1'b1, MAC3, 32'hC0A80168);

    repeat (5) @(negedge clk);
    check("final_queue", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
